// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if
//   Bundles the two requester ports (CPU load/store, AXI-Lite host) and the
//   ideal_mem port-2 drive of riscv_mem_arbiter.
//   slave  : arbiter side (takes reqs and mem_rdata, drives acks/resp/mem).
//   master : requesters plus memory side (drives reqs and mem_rdata).
//   Params : ADDR_W - word-address width of ideal_mem port 2.
interface riscv_mem_arbiter_if #(parameter int ADDR_W = 9);
  logic              cpu_hold;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ack, cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_ack, host_rvalid;
  logic [31:0]       host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rden, mem_wren;
  logic [31:0]       mem_wdata, mem_rdata;

  modport slave (
    input  cpu_hold, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output cpu_ack, cpu_rvalid, cpu_rdata, host_ack, host_rvalid, host_rdata,
    output mem_addr, mem_rden, mem_wren, mem_wdata
  );

  modport master (
    output cpu_hold, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata, host_ack, host_rvalid, host_rdata,
    input  mem_addr, mem_rden, mem_wren, mem_wdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Registered two-port arbiter in front of ideal_mem port 2, shared between
//   the CPU load/store path and the AXI-Lite host path. Grant is combinational
//   in the request cycle, CPU has priority, and a host refused MAX_WAIT cycles
//   in a row gets a one-cycle forced grant. Read data returns one cycle after
//   the read ack through per-requester rdata registers.
// Ports
//   riscv_cpu_clk   - clock
//   riscv_cpu_reset - asynchronous reset, active-high
//   bus             - riscv_mem_arbiter_if.slave (requesters + mem drive)
//   stat_conflict   - (ARB_STATS_EN) cycles with both effective reqs high
//   stat_forced     - (ARB_STATS_EN) forced host grants
// Params
//   ADDR_W   - word-address width
//   MAX_WAIT - refused host cycles before a forced host grant (1..255)
// Config macro
//   ARB_STATS_EN - adds the two wrapping 32-bit statistics counters.
module riscv_mem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic                 riscv_cpu_clk,
  input  logic                 riscv_cpu_reset,
  riscv_mem_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]          stat_conflict,
  output logic [31:0]          stat_forced
`endif
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic              cpu_eff, forced, cpu_win, host_win;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, host_rvalid_q, host_rvalid_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rden, mem_wren;

  always_comb begin
    cpu_eff   = bus.cpu_req & ~bus.cpu_hold;
    // Forced only when the host actually beats a live CPU request.
    forced    = bus.host_req & cpu_eff & (wait_cnt_q == MAX_W);
    host_win  = bus.host_req & (~cpu_eff | forced);
    cpu_win   = cpu_eff & ~host_win;

    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    if (cpu_win) begin
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
      mem_wren  = bus.cpu_we;
      mem_rden  = ~bus.cpu_we;
    end else if (host_win) begin
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
      mem_wren  = bus.host_we;
      mem_rden  = ~bus.host_we;
    end

    wait_cnt_d = wait_cnt_q;
    if (!bus.host_req || host_win)  wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_W)   wait_cnt_d = wait_cnt_q + 8'd1;

    // rvalid is a one-cycle pulse; rdata holds until the next read response.
    cpu_rvalid_d  = cpu_win & ~bus.cpu_we;
    host_rvalid_d = host_win & ~bus.host_we;
    cpu_rdata_d   = cpu_rvalid_d  ? bus.mem_rdata : cpu_rdata_q;
    host_rdata_d  = host_rvalid_d ? bus.mem_rdata : host_rdata_q;
  end

  always_ff @(posedge riscv_cpu_clk or posedge riscv_cpu_reset) begin
    if (riscv_cpu_reset) begin
      wait_cnt_q    <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.cpu_ack     = cpu_win;
  assign bus.host_ack    = host_win;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.mem_wren    = mem_wren;
  assign bus.mem_rden    = mem_rden;

`ifdef ARB_STATS_EN
  logic [31:0] stat_conflict_q, stat_conflict_d, stat_forced_q, stat_forced_d;

  always_comb begin
    stat_conflict_d = stat_conflict_q + {31'd0, cpu_eff & bus.host_req};
    stat_forced_d   = stat_forced_q + {31'd0, forced};
  end

  always_ff @(posedge riscv_cpu_clk or posedge riscv_cpu_reset) begin
    if (riscv_cpu_reset) begin
      stat_conflict_q <= '0;
      stat_forced_q   <= '0;
    end else begin
      stat_conflict_q <= stat_conflict_d;
      stat_forced_q   <= stat_forced_d;
    end
  end

  assign stat_conflict = stat_conflict_q;
  assign stat_forced   = stat_forced_q;
`endif

endmodule
